// File: rtl/s13207_cnt_chain.sv
// -----------------------------------------------------------------------------
// s13207_cnt_chain
//
// Register side of the s13207 counter-chain cone. Holds the counter state
// that the combinational partial-output cones evaluate, and produces the
// registered terminal-count pulse, sticky overflow flag and busy indication.
//
// Function: gated binary up-counter with synchronous clear, synchronous
// parallel load, a freeze input, a terminal count that wraps to zero, and an
// overflow flag cleared by an acknowledge handshake.
//
// Per-cycle priority, highest first:
//   clr > g1251 (freeze) > ld > increment (en) > hold
//   en = g150 & ~g1034 & ~g1251
//
// Parameters:
//   WIDTH     counter width in bits (2..16)
//   TC_VALUE  terminal count; an increment from this value wraps to 0.
//             Must be < 2**WIDTH.
//
// Ports:
//   CK      in   rising-edge clock
//   RN      in   asynchronous active-low reset
//   g150    in   count request
//   g1034   in   count inhibit, active high
//   g1251   in   freeze, active high (overrides everything except reset/clr)
//   clr     in   synchronous clear of cnt/tc (ovf untouched)
//   ld      in   synchronous parallel load
//   ld_val  in   load value [WIDTH-1:0]
//   ack     in   overflow acknowledge
//   cnt     out  counter state [WIDTH-1:0], registered
//   tc      out  one-cycle terminal-count pulse, registered
//   ovf     out  sticky overflow flag, registered
//   busy    out  registered (cnt != 0), updates with cnt
// -----------------------------------------------------------------------------
module s13207_cnt_chain #(
  parameter int WIDTH    = 12,
  parameter int TC_VALUE = 4095
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             g150,
  input  logic             g1034,
  input  logic             g1251,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             ack,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] TC_LIM = WIDTH'(TC_VALUE);

  // Overflow handshake states.
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] FLAGGED = 1'b1;

  // Counter advance: wraps to zero at the terminal count, otherwise adds one
  // modulo 2**WIDTH (so values above TC_VALUE roll over naturally).
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] val);
    if (val == TC_LIM) begin
      advance = '0;
    end else begin
      advance = val + WIDTH'(1);
    end
  endfunction

  logic [WIDTH-1:0] cnt_p1;
  logic             tc_p1;
  logic             busy_p1;
  logic [0:0]       ovf_state_p1;

  logic             en;
  logic             wrap;
  logic [WIDTH-1:0] cnt_nxt;
  logic [0:0]       ovf_state_nxt;

  // Same gating as the cone term (~g1034 & g150), further qualified by freeze.
  assign en = g150 & ~g1034 & ~g1251;

  // A wrap only happens when the increment branch is actually taken, i.e.
  // neither clear nor load (freeze is already folded into en).
  assign wrap = ~clr & ~ld & en & (cnt_p1 == TC_LIM);

  always_comb begin
    cnt_nxt = cnt_p1;
    if (clr) begin
      cnt_nxt = '0;
    end else if (g1251) begin
      cnt_nxt = cnt_p1;
    end else if (ld) begin
      cnt_nxt = ld_val;
    end else if (en) begin
      cnt_nxt = advance(cnt_p1);
    end
  end

  // A wrap in the same cycle as ack beats the acknowledge.
  always_comb begin
    ovf_state_nxt = ovf_state_p1;
    case (ovf_state_p1)
      IDLE:    if (wrap)        ovf_state_nxt = FLAGGED;
      FLAGGED: if (ack && !wrap) ovf_state_nxt = IDLE;
      default: ovf_state_nxt = IDLE;
    endcase
  end

  // ---- register stage p1: counter, pulse, busy, overflow FSM ----
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt_p1       <= '0;
      tc_p1        <= 1'b0;
      busy_p1      <= 1'b0;
      ovf_state_p1 <= IDLE;
    end else begin
      cnt_p1       <= cnt_nxt;
      tc_p1        <= wrap;
      busy_p1      <= (cnt_nxt != '0);
      ovf_state_p1 <= ovf_state_nxt;
    end
  end

  assign cnt  = cnt_p1;
  assign tc   = tc_p1;
  assign busy = busy_p1;
  assign ovf  = (ovf_state_p1 == FLAGGED);

endmodule

// File: tb/tb_s13207_cnt_chain.sv
// -----------------------------------------------------------------------------
// tb_s13207_cnt_chain
//
// Drives two instances from shared stimulus: the default 12-bit counter with
// natural wrap at 4095, and a 4-bit counter with terminal count 9 (wrap below
// the natural limit). A behavioural model tracks each instance from the
// counter rules; directed sequences are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_s13207_cnt_chain;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        g150 = 1'b0, g1034 = 1'b0, g1251 = 1'b0;
  logic        clr = 1'b0, ld = 1'b0, ack = 1'b0;
  logic [11:0] ld_val = '0;

  logic [11:0] cnt_a;
  logic        tc_a, ovf_a, busy_a;
  logic [3:0]  cnt_b;
  logic        tc_b, ovf_b, busy_b;

  int checks = 0;
  int errors = 0;

  // Model state per instance: index 0 = 12-bit/4095, index 1 = 4-bit/9.
  int m_cnt [2];
  int m_tc  [2];
  int m_ovf [2];
  int m_mod [2] = '{4096, 16};
  int m_term[2] = '{4095, 9};

  s13207_cnt_chain dut_a (
    .CK(CK), .RN(RN), .g150(g150), .g1034(g1034), .g1251(g1251),
    .clr(clr), .ld(ld), .ld_val(ld_val), .ack(ack),
    .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a), .busy(busy_a)
  );

  s13207_cnt_chain #(.WIDTH(4), .TC_VALUE(9)) dut_b (
    .CK(CK), .RN(RN), .g150(g150), .g1034(g1034), .g1251(g1251),
    .clr(clr), .ld(ld), .ld_val(ld_val[3:0]), .ack(ack),
    .cnt(cnt_b), .tc(tc_b), .ovf(ovf_b), .busy(busy_b)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_cnt",  int'(cnt_a),  m_cnt[0]);
    chk("a_tc",   int'(tc_a),   m_tc[0]);
    chk("a_ovf",  int'(ovf_a),  m_ovf[0]);
    chk("a_busy", int'(busy_a), (m_cnt[0] != 0) ? 1 : 0);
    chk("b_cnt",  int'(cnt_b),  m_cnt[1]);
    chk("b_tc",   int'(tc_b),   m_tc[1]);
    chk("b_ovf",  int'(ovf_b),  m_ovf[1]);
    chk("b_busy", int'(busy_b), (m_cnt[1] != 0) ? 1 : 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_tc[k]  = 0;
      m_ovf[k] = 0;
    end
  endtask

  // Predict the next state from the inputs present at the coming edge, clock
  // once, then compare every output.
  task automatic step();
    int nc[2];
    int nt[2];
    int no[2];
    bit en;
    en = g150 && !g1034 && !g1251;
    for (int k = 0; k < 2; k++) begin
      nc[k] = m_cnt[k];
      nt[k] = 0;
      no[k] = m_ovf[k];
      if (clr)          nc[k] = 0;
      else if (g1251)   nc[k] = m_cnt[k];
      else if (ld)      nc[k] = int'(ld_val) % m_mod[k];
      else if (en) begin
        if (m_cnt[k] == m_term[k]) begin
          nc[k] = 0;
          nt[k] = 1;
        end else begin
          nc[k] = (m_cnt[k] + 1) % m_mod[k];
        end
      end
      if (nt[k] == 1)             no[k] = 1;
      else if (ack)               no[k] = 0;
    end
    @(posedge CK);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = nc[k];
      m_tc[k]  = nt[k];
      m_ovf[k] = no[k];
    end
    check_all();
  endtask

  // Assert RN between edges (called #1 after an edge), check the immediate
  // effect, then release before the next edge.
  task automatic async_reset();
    #3;
    RN = 1'b0;
    #1;
    model_reset();
    chk("arst_cnt", int'(cnt_a), 0);
    chk("arst_ovf", int'(ovf_a), 0);
    chk("arst_tc",  int'(tc_a),  0);
    check_all();
    #2;
    RN = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset values while RN is low.
    #12;
    check_all();
    chk("rst_busy", int'(busy_a), 0);
    RN = 1'b1;

    // Free count.
    g150 = 1'b1;
    repeat (5) step();
    chk("free_cnt5", int'(cnt_a), 5);
    chk("free_busy", int'(busy_a), 1);

    // Inhibit, then freeze ignoring load, then load.
    g1034 = 1'b1;
    repeat (3) step();
    chk("inhibit_hold", int'(cnt_a), 5);
    g1034 = 1'b0; g1251 = 1'b1; ld = 1'b1; ld_val = 12'd100;
    step();
    chk("freeze_ld", int'(cnt_a), 5);
    g1251 = 1'b0;
    step();
    chk("ld100", int'(cnt_a), 100);

    // Wrap at 4095 with tc pulse and overflow.
    ld_val = 12'd4094;
    step();
    ld = 1'b0;
    step();
    chk("pre_wrap", int'(cnt_a), 4095);
    chk("pre_wrap_tc", int'(tc_a), 0);
    step();
    chk("wrap_cnt", int'(cnt_a), 0);
    chk("wrap_tc", int'(tc_a), 1);
    chk("wrap_ovf", int'(ovf_a), 1);
    chk("wrap_busy", int'(busy_a), 0);
    step();
    chk("tc_pulse_end", int'(tc_a), 0);

    // Acknowledge clears the flag.
    g150 = 1'b0; ack = 1'b1;
    step();
    chk("ack_clear", int'(ovf_a), 0);
    ack = 1'b0;

    // Wrap again, then wrap while acknowledging: flag must stay set.
    ld = 1'b1; ld_val = 12'd4095; g150 = 1'b1;
    step();
    ld = 1'b0;
    step();
    chk("rewrap_ovf", int'(ovf_a), 1);
    ld = 1'b1;
    step();
    ld = 1'b0; ack = 1'b1;
    step();
    chk("wrap_vs_ack", int'(ovf_a), 1);
    chk("wrap_vs_ack_tc", int'(tc_a), 1);
    ack = 1'b0;

    // Priority: clear beats load and increment; load beats increment.
    ld = 1'b1; ld_val = 12'd55;
    step();
    chk("ld55", int'(cnt_a), 55);
    clr = 1'b1; ld_val = 12'd9;
    step();
    chk("clr_prio", int'(cnt_a), 0);
    chk("clr_keeps_ovf", int'(ovf_a), 1);
    clr = 1'b0; ld_val = 12'd7;
    step();
    chk("ld_over_inc", int'(cnt_a), 7);

    // Asynchronous reset at cnt=300 with ovf set.
    ld_val = 12'd299;
    step();
    ld = 1'b0;
    step();
    chk("pre_arst_cnt", int'(cnt_a), 300);
    chk("pre_arst_ovf", int'(ovf_a), 1);
    async_reset();
    step();
    chk("post_arst_cnt", int'(cnt_a), 1);

    // Randomized traffic, loads biased near the 12-bit terminal count.
    for (int i = 0; i < 800; i++) begin
      g150  = ($urandom_range(0, 3) != 0);
      g1034 = ($urandom_range(0, 7) == 0);
      g1251 = ($urandom_range(0, 9) == 0);
      clr   = ($urandom_range(0, 19) == 0);
      ld    = ($urandom_range(0, 9) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) ld_val = 12'(4088 + $urandom_range(0, 7));
      else                           ld_val = 12'($urandom_range(0, 4095));
      step();
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
